// File: rtl/guess_judge_if.sv
// Guess-judge bus: round control, guess strobe and judge results.
// The block side uses the slave modport; the stimulus side uses master.
interface guess_judge_if;
  logic       start;
  logic [3:0] rand_in;
  logic       guess_valid;
  logic [3:0] guess;
  logic       change_answer;
  logic [3:0] answer;
  logic [1:0] hint;
  logic [2:0] tries;
  logic       win;
  logic       lose;
  logic       ready;

  modport slave (
    input  start, rand_in, guess_valid, guess,
    output change_answer, answer, hint, tries, win, lose, ready
  );

  modport master (
    output start, rand_in, guess_valid, guess,
    input  change_answer, answer, hint, tries, win, lose, ready
  );
endinterface

// File: rtl/guess_judge.sv
// Number-guessing round controller: requests an answer from the random
// generator, judges player guesses (higher / lower / correct) and counts tries.
// Optional macro GUESS_LIMIT_EN: ends the round in LOSE after MAX_TRIES
// wrong guesses; without it LOSE is unreachable and lose stays 0.
module guess_judge #(
  parameter int MAX_TRIES = 4
) (
  input  logic          clk50M,
  input  logic          rst_n,
  guess_judge_if.slave  bus
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_REQ   = 3'd1;
  localparam logic [2:0] S_LOAD  = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_JUDGE = 3'd4;
  localparam logic [2:0] S_WIN   = 3'd5;
  localparam logic [2:0] S_LOSE  = 3'd6;

`ifdef GUESS_LIMIT_EN
  localparam logic [2:0] LP_MAX_TRIES = MAX_TRIES[2:0];
`endif

  logic [2:0] r_state;
  logic [2:0] w_state_next;
  logic [3:0] r_answer;
  logic [3:0] r_guess;
  logic [1:0] r_hint;
  logic [2:0] r_tries;

  logic       w_guess_ok;
  logic       w_rand_ok;
  logic       w_accept;
  logic       w_hit;
  logic [2:0] w_tries_inc;
  logic [1:0] w_hint_cmp;

  // Only values 1..8 are legal answers / guesses
  assign w_guess_ok  = (bus.guess != 4'd0) && (bus.guess <= 4'd8);
  assign w_rand_ok   = (bus.rand_in != 4'd0) && (bus.rand_in <= 4'd8);
  // start has priority over a simultaneous guess in WAIT
  assign w_accept    = (r_state == S_WAIT) && !bus.start && bus.guess_valid && w_guess_ok;
  assign w_hit       = (r_answer == r_guess);
  // tries saturates at 7 rather than wrapping
  assign w_tries_inc = (r_tries == 3'd7) ? 3'd7 : r_tries + 3'd1;
  assign w_hint_cmp  = (r_answer > r_guess) ? 2'b01 :
                       (r_answer < r_guess) ? 2'b10 : 2'b11;

  // Next-state selection for the round FSM
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (bus.start) w_state_next = S_REQ;
      S_REQ:   w_state_next = S_LOAD;
      S_LOAD:  w_state_next = S_WAIT;
      S_WAIT: begin
        if (bus.start)     w_state_next = S_REQ;
        else if (w_accept) w_state_next = S_JUDGE;
      end
      S_JUDGE: begin
        if (bus.start)  w_state_next = S_REQ;
        else if (w_hit) w_state_next = S_WIN;
`ifdef GUESS_LIMIT_EN
        else if (w_tries_inc == LP_MAX_TRIES) w_state_next = S_LOSE;
`endif
        else            w_state_next = S_WAIT;
      end
      S_WIN, S_LOSE: if (bus.start) w_state_next = S_REQ;
      default: w_state_next = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk50M or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  // Answer capture in LOAD, illegal generator values replaced by 1
  always_ff @(posedge clk50M or negedge rst_n) begin
    if (!rst_n)                  r_answer <= 4'd0;
    else if (r_state == S_LOAD)  r_answer <= w_rand_ok ? bus.rand_in : 4'd1;
  end

  // Guess register, loaded only when a legal guess is accepted
  always_ff @(posedge clk50M or negedge rst_n) begin
    if (!rst_n)        r_guess <= 4'd0;
    else if (w_accept) r_guess <= bus.guess;
  end

  // Round results: cleared on entry to REQ, updated once per JUDGE
  always_ff @(posedge clk50M or negedge rst_n) begin
    if (!rst_n) begin
      r_hint  <= 2'b00;
      r_tries <= 3'd0;
    end else if (w_state_next == S_REQ && r_state != S_REQ) begin
      r_hint  <= 2'b00;
      r_tries <= 3'd0;
    end else if (r_state == S_JUDGE) begin
      r_hint  <= w_hint_cmp;
      r_tries <= w_tries_inc;
    end
  end

  assign bus.change_answer = (r_state == S_REQ);
  assign bus.ready         = (r_state == S_WAIT);
  assign bus.win           = (r_state == S_WIN);
`ifdef GUESS_LIMIT_EN
  assign bus.lose          = (r_state == S_LOSE);
`else
  assign bus.lose          = 1'b0;
`endif
  assign bus.answer        = r_answer;
  assign bus.hint          = r_hint;
  assign bus.tries         = r_tries;

endmodule
